canny_seq_ctrl: RTL and testbench

- Sequencer for the Canny datapath: buffer block, shifter block, hold blocks, multiplier blocks and output block.
- Replaces the free-running cycle-count schedule with an explicit per-step FSM.
- Generates the SRAM read address, the one-cycle stage enables, the early-refill request (getNext) and frame start/done handshakes.
- Sits between the frame-level control (startEn) and the Canny datapath instances.

---
 rtl/canny_pkg.sv | 36 +++
 rtl/canny_seq_ctrl_if.sv | 33 +++
 rtl/canny_addr_gen.sv | 82 ++++++++
 rtl/canny_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_canny_seq_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny sequencer and its SRAM model.
// Contents: default image geometry, SRAM read latency default, FSM state
// encoding, and a helper that sizes counters.
package canny_pkg;

    // Default image geometry: 512x512 pixels, 8 pixels per 64-bit word.
    localparam int unsigned IMG_W             = 512;
    localparam int unsigned IMG_H             = 512;
    localparam int unsigned PX_PER_WORD       = 8;
    localparam int unsigned DEF_WORDS_PER_ROW = IMG_W / PX_PER_WORD;
    localparam int unsigned DEF_ROWS          = IMG_H;
    localparam int unsigned DEF_ROW_STEP      = 2;
    localparam int unsigned DEF_ADDR_W        = 20;
    localparam int unsigned DEF_SHIFT_CYCLES  = 2;
    localparam int unsigned DEF_GETNEXT_ROW   = 408;

    // SRAM read latency; the SRAM model uses this same value.
    localparam int unsigned DEF_RD_LAT        = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPop,
        StShift,
        StHold,
        StMult,
        StOut,
        StDone
    } seq_state_e;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/canny_seq_ctrl_if.sv
// Handshake bundle between the Canny sequencer and the datapath.
// master: sequencer side (takes startEn/out_ready, drives address, enables,
//         getNext, busy, frame_done).
// slave:  frame control / datapath side (mirror image of master).
interface canny_seq_ctrl_if
    import canny_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              startEn;
    logic              out_ready;
    logic [ADDR_W-1:0] read_addr;
    logic              popBufferEn;
    logic              cannyShiftEn;
    logic              HoldEn;
    logic              startMultiplierEn;
    logic              outEn;
    logic              getNext;
    logic              busy;
    logic              frame_done;

    modport master (
        input  startEn, out_ready,
        output read_addr, popBufferEn, cannyShiftEn, HoldEn, startMultiplierEn,
               outEn, getNext, busy, frame_done
    );

    modport slave (
        output startEn, out_ready,
        input  read_addr, popBufferEn, cannyShiftEn, HoldEn, startMultiplierEn,
               outEn, getNext, busy, frame_done
    );
endinterface

// File: rtl/canny_addr_gen.sv
// Row/column walker for the Canny sequencer.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   step_advance    - move to the next step (col+1, wrapping into row+ROW_STEP)
//   frame_clear     - restart at row 0, col 0
//   first_fetch     - high on the first FETCH cycle of a step
//   read_addr       - registered row*WORDS_PER_ROW + col
//   last_step       - current step is the final one of the frame
//   getnext_hit     - first_fetch on the step (GETNEXT_ROW, 0)
module canny_addr_gen
    import canny_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int unsigned ROWS          = DEF_ROWS,
    parameter int unsigned ROW_STEP      = DEF_ROW_STEP,
    parameter int unsigned GETNEXT_ROW   = DEF_GETNEXT_ROW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_advance,
    input  logic              frame_clear,
    input  logic              first_fetch,
    output logic [ADDR_W-1:0] read_addr,
    output logic              last_step,
    output logic              getnext_hit
);
    localparam int unsigned RowW = cnt_width(ROWS);
    localparam int unsigned ColW = cnt_width(WORDS_PER_ROW);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - ROW_STEP);
    localparam logic [ColW-1:0] ColLast = ColW'(WORDS_PER_ROW - 1);
    localparam logic [RowW-1:0] RowGn   = RowW'(GETNEXT_ROW);

    if (64'(ROWS) * 64'(WORDS_PER_ROW) > (64'd1 << ADDR_W)) begin : g_addr_range_chk
        $error("ROWS*WORDS_PER_ROW does not fit in ADDR_W address bits");
    end
    if (GETNEXT_ROW >= ROWS || (GETNEXT_ROW % ROW_STEP) != 0) begin : g_getnext_chk
        $error("GETNEXT_ROW must be a multiple of ROW_STEP below ROWS");
    end

    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (frame_clear) begin
            row_d = '0;
            col_d = '0;
        end else if (step_advance) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + RowW'(ROW_STEP);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
        // Address only moves when a new step begins, so it is stable FETCH..OUT.
        if (frame_clear || step_advance) begin
            addr_d = ADDR_W'(row_d) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(col_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign read_addr   = addr_q;
    assign last_step   = (row_q == RowLast) && (col_q == ColLast);
    assign getnext_hit = first_fetch && (row_q == RowGn) && (col_q == '0);

endmodule

// File: rtl/canny_seq_ctrl.sv
// Per-step sequencer for the Canny datapath. Walks the image in ROW_STEP row
// pairs, and for each word runs FETCH -> POP -> SHIFT -> HOLD -> MULT -> OUT,
// then DONE at the end of the frame.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - master side of canny_seq_ctrl_if (startEn, out_ready in;
//            read_addr, stage enables, getNext, busy, frame_done out)
module canny_seq_ctrl
    import canny_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int unsigned ROWS          = DEF_ROWS,
    parameter int unsigned ROW_STEP      = DEF_ROW_STEP,
    parameter int unsigned RD_LAT        = DEF_RD_LAT,
    parameter int unsigned SHIFT_CYCLES  = DEF_SHIFT_CYCLES,
    parameter int unsigned GETNEXT_ROW   = DEF_GETNEXT_ROW
) (
    input logic              clk,
    input logic              reset,
    canny_seq_ctrl_if.master bus
);
    localparam int unsigned CntMax = (RD_LAT > SHIFT_CYCLES) ? RD_LAT : SHIFT_CYCLES;
    localparam int unsigned CntW   = cnt_width(CntMax);

    if (RD_LAT < 1 || SHIFT_CYCLES < 1) begin : g_lat_chk
        $error("RD_LAT and SHIFT_CYCLES must be at least 1");
    end

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_advance, frame_clear, first_fetch;
    logic            last_step, getnext_hit;

    canny_addr_gen #(
        .ADDR_W        (ADDR_W),
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .ROWS          (ROWS),
        .ROW_STEP      (ROW_STEP),
        .GETNEXT_ROW   (GETNEXT_ROW)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .step_advance (step_advance),
        .frame_clear  (frame_clear),
        .first_fetch  (first_fetch),
        .read_addr    (bus.read_addr),
        .last_step    (last_step),
        .getnext_hit  (getnext_hit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_advance = 1'b0;
        frame_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.startEn) begin
                    frame_clear = 1'b1;
                    cnt_d       = '0;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (cnt_q == CntW'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StPop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPop: begin
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == CntW'(SHIFT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: state_d = StMult;
            StMult: state_d = StOut;
            StOut: begin
                if (bus.out_ready) begin
                    if (last_step) begin
                        state_d = StDone;
                    end else begin
                        step_advance = 1'b1;
                        cnt_d        = '0;
                        state_d      = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only reachable once per step, so an OUT stall cannot re-fire getNext.
    assign first_fetch = (state_q == StFetch) && (cnt_q == '0);

    // Outputs decode the state register only; outEn alone sees out_ready.
    assign bus.popBufferEn       = (state_q == StPop);
    assign bus.cannyShiftEn      = (state_q == StShift) || (state_q == StHold);
    assign bus.HoldEn            = (state_q == StHold);
    assign bus.startMultiplierEn = (state_q == StMult);
    assign bus.outEn             = (state_q == StOut) && bus.out_ready;
    assign bus.getNext           = getnext_hit;
    assign bus.busy              = (state_q != StIdle);
    assign bus.frame_done        = (state_q == StDone);

endmodule

// File: tb/tb_canny_seq_ctrl.sv
// Directed bench for canny_seq_ctrl on a 4-word x 4-row image.
module tb_canny_seq_ctrl;
    import canny_pkg::*;

    localparam int unsigned AW    = 20;
    localparam int unsigned WPR   = 4;
    localparam int unsigned NROWS = 4;
    localparam int unsigned RSTEP = 2;
    localparam int unsigned RLAT  = 2;
    localparam int unsigned SHC   = 2;
    localparam int unsigned GNROW = 2;

    logic clk = 1'b0;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int gn_cnt   = 0;
    int cyc      = 0;

    // Step addresses: rows 0 and 2 (row step 2), four words each.
    int exp_addr [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    // {pop, shift, hold, mult, outEn, getNext, frame_done} per step cycle.
    logic [6:0] pat [8] = '{7'b0000000, 7'b0000000, 7'b1000000, 7'b0100000,
                            7'b0100000, 7'b0110000, 7'b0001000, 7'b0000100};

    canny_seq_ctrl_if #(.ADDR_W(AW)) bus ();

    canny_seq_ctrl #(
        .ADDR_W        (AW),
        .WORDS_PER_ROW (WPR),
        .ROWS          (NROWS),
        .ROW_STEP      (RSTEP),
        .RD_LAT        (RLAT),
        .SHIFT_CYCLES  (SHC),
        .GETNEXT_ROW   (GNROW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] vec();
        return {bus.popBufferEn, bus.cannyShiftEn, bus.HoldEn, bus.startMultiplierEn,
                bus.outEn, bus.getNext, bus.frame_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.busy === 1'b1)       busy_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.getNext === 1'b1)    gn_cnt++;
    endtask

    // Stage enables never overlap, except shift alongside hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_assert++;
            assert ($countones({bus.popBufferEn, bus.cannyShiftEn, bus.startMultiplierEn,
                                bus.outEn}) <= 1 && (!bus.HoldEn || bus.cannyShiftEn))
            else begin
                n_fail++;
                $error("FAIL mutex: observed %b, expected at most one enable",
                       {bus.popBufferEn, bus.cannyShiftEn, bus.HoldEn,
                        bus.startMultiplierEn, bus.outEn});
            end
        end
    end

    // One whole frame from IDLE, ending on the DONE cycle.
    task automatic run_frame(input int stall_step, input int stall_len, input int poke_cyc);
        logic [6:0] e;
        busy_cnt = 0;
        done_cnt = 0;
        gn_cnt   = 0;
        cyc      = 0;
        bus.out_ready = 1'b1;
        bus.startEn   = 1'b1;
        tick();
        bus.startEn = 1'b0;
        chk("busy_rise", 32'(bus.busy), 1);
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 8; c++) begin
                if (s == stall_step && c == 7) begin
                    for (int k = 0; k < stall_len; k++) begin
                        chk($sformatf("stall_s%0d_vec", s), 32'(vec()), 0);
                        chk($sformatf("stall_s%0d_addr", s), 32'(bus.read_addr), exp_addr[s]);
                        tick();
                    end
                    bus.out_ready = 1'b1;
                    #1;
                end
                e = pat[c];
                if (s == 4 && c == 0) e = e | 7'b0000010;
                chk($sformatf("s%0d_c%0d_vec", s, c), 32'(vec()), 32'(e));
                chk($sformatf("s%0d_c%0d_addr", s, c), 32'(bus.read_addr), exp_addr[s]);
                if (s == stall_step && c == 6) bus.out_ready = 1'b0;
                if (cyc == poke_cyc) bus.startEn = 1'b1;
                tick();
                bus.startEn = 1'b0;
            end
        end
        chk("done_pulse", 32'(bus.frame_done), 1);
        chk("done_busy", 32'(bus.busy), 1);
        chk("frame_len", busy_cnt, 65 + stall_len);
        chk("done_count", done_cnt, 1);
        chk("getnext_count", gn_cnt, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.startEn   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_vec", 32'(vec()), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_addr", 32'(bus.read_addr), 0);
        tick();
        bus.startEn = 1'b1;
        tick();
        chk("rst_start_ignored", 32'(bus.busy), 0);
        bus.startEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'(bus.busy), 0);

        // Basic frame with per-cycle enable pattern.
        run_frame(-1, 0, -1);

        // startEn held through DONE: ignored there, accepted in IDLE.
        bus.startEn = 1'b1;
        tick();
        chk("done_start_ignored", 32'(bus.busy), 0);
        chk("idle_no_done", 32'(bus.frame_done), 0);
        tick();
        bus.startEn = 1'b0;
        chk("idle_start_accepted", 32'(bus.busy), 1);
        chk("restart_addr", 32'(bus.read_addr), 0);

        // Reset mid-frame at busy cycle 30 (step addr 3).
        done_cnt = 0;
        gn_cnt   = 0;
        repeat (29) tick();
        chk("pre_reset_busy", 32'(bus.busy), 1);
        chk("pre_reset_addr", 32'(bus.read_addr), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec", 32'(vec()), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_addr", 32'(bus.read_addr), 0);
        repeat (3) tick();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_getnext", gn_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_after_mid_rst", 32'(bus.busy), 0);

        // Restart from addr 0, with a stray startEn at busy cycle 20.
        run_frame(-1, 0, 20);
        tick();
        chk("idle_after_poke_frame", 32'(bus.busy), 0);

        // Five-cycle OUT stall on the third step (addr 2).
        run_frame(2, 5, -1);
        tick();
        chk("idle_after_stall_frame", 32'(bus.busy), 0);

        // Stall on the getNext step (addr 8): getNext must not repeat.
        run_frame(4, 3, -1);
        tick();
        chk("idle_after_gn_stall", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
